// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - sram-like inst/data request channels to a single-beat AXI3 master
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

  r_state_e            r_state_q, r_state_d;
  w_state_e            w_state_q, w_state_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [2:0]          ar_size_q, ar_size_d;
  logic                ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [2:0]          aw_size_q, aw_size_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                b_ok_q, b_ok_d;
  logic                data_rd_go, inst_rd_go, data_wr_go, r_hs;
  logic                unused_axi;

  // Responses are single-beat, so status and id fields on R/B beyond rid are not needed.
  assign unused_axi = ^{rresp, rlast, bid, bresp};

  // A data read waits for the write FSM so it can never overtake a store still in flight.
  always_comb begin
    data_rd_go = (r_state_q == R_IDLE) && data_req && !data_wr && (w_state_q == W_IDLE);
    inst_rd_go = (r_state_q == R_IDLE) && inst_req && !data_rd_go;
    data_wr_go = (w_state_q == W_IDLE) && data_req && data_wr &&
                 ((r_state_q == R_IDLE) || !ar_id_q);
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_size_d = ar_size_q;
    ar_id_d   = ar_id_q;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_go) begin
          ar_addr_d = data_addr;
          ar_size_d = {1'b0, data_size};
          ar_id_d   = 1'b1;
          r_state_d = R_AR;
        end else if (inst_rd_go) begin
          ar_addr_d = inst_addr;
          ar_size_d = {1'b0, inst_size};
          ar_id_d   = 1'b0;
          r_state_d = R_AR;
        end
      end
      R_AR:    if (arready) r_state_d = R_R;
      R_R:     if (rvalid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_size_d  = aw_size_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ok_d     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_go) begin
          aw_addr_d  = data_addr;
          aw_size_d  = {1'b0, data_size};
          w_data_d   = data_wdata;
          w_strb_d   = data_wstrb;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          w_state_d  = W_REQ;
        end
      end
      W_REQ: begin
        aw_valid_d = aw_valid_q && !awready;
        w_valid_d  = w_valid_q && !wready;
        if (!aw_valid_d && !w_valid_d) w_state_d = W_B;
      end
      W_B: begin
        if (bvalid) begin
          b_ok_d    = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_id_q    <= 1'b0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ok_q     <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_id_q    <= ar_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_size_q  <= aw_size_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ok_q     <= b_ok_d;
    end
  end

  assign r_hs         = (r_state_q == R_R) && rvalid;
  assign inst_addr_ok = inst_rd_go;
  assign data_addr_ok = data_rd_go || data_wr_go;
  assign inst_data_ok = r_hs && (rid == 4'd0);
  assign data_data_ok = (r_hs && (rid == 4'd1)) || b_ok_q;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = {3'b000, ar_id_q};
  assign araddr  = ar_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = ar_size_q;
  assign arburst = 2'd1;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);

  assign awid    = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = aw_size_q;
  assign awburst = 2'd1;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = aw_valid_q;
  assign wid     = 4'd1;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = w_valid_q;
  assign bready  = (w_state_q == W_B);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - randomized scoreboard bench for sram_axi_bridge
module tb_sram_axi_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [3:0]  gap;
  } cmd_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] size; logic [3:0] id; } ar_t;
  typedef struct packed { logic wr; logic [31:0] rdata; } drsp_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;

  cmd_t        inst_cmd_q[$], data_cmd_q[$];
  ar_t         ar_exp_q[$], aw_exp_q[$], r_pend[$];
  logic [31:0] inst_rsp_q[$];
  drsp_t       data_rsp_q[$];
  w_t          w_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic hold_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic cmd_t mk(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                              input logic [3:0] st, input logic [31:0] wd, input logic [3:0] g);
    cmd_t c;
    c.wr = wr; c.addr = a; c.size = sz; c.strb = st; c.wdata = wd; c.gap = g;
    return c;
  endfunction

  // Handshake observations and the spec-level occupancy model, maintained by the monitor.
  logic        inst_acc, data_acc, ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic [31:0] ar_cap_addr;
  logic [3:0]  ar_cap_id;
  logic        rd_busy, rd_id, wr_busy, b_prev, ar_wait;
  logic [31:0] ar_wait_addr;
  int          wr_acc, aw_cnt, w_cnt, b_cnt;

  // CPU-side driver: holds each request until the cycle it is accepted.
  int   inst_gap, data_gap;
  cmd_t ic, dc;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      inst_req = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_gap = 0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = '0;
      data_addr = '0; data_wdata = '0; data_gap = 0;
    end else begin
      if (inst_acc) inst_req = 1'b0;
      if (data_acc) data_req = 1'b0;
      if (!inst_req && inst_cmd_q.size() > 0) begin
        if (inst_gap < int'(inst_cmd_q[0].gap)) inst_gap++;
        else begin
          ic = inst_cmd_q.pop_front();
          inst_req = 1'b1; inst_addr = ic.addr; inst_size = ic.size; inst_gap = 0;
        end
      end
      if (!data_req && data_cmd_q.size() > 0) begin
        if (data_gap < int'(data_cmd_q[0].gap)) data_gap++;
        else begin
          dc = data_cmd_q.pop_front();
          data_req = 1'b1; data_wr = dc.wr; data_addr = dc.addr; data_size = dc.size;
          data_wstrb = dc.strb; data_wdata = dc.wdata; data_gap = 0;
        end
      end
    end
  end

  // AXI slave with random ready/valid timing; read data comes from mem_word().
  int  s_aw, s_w, s_b;
  ar_t rp;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
      r_pend.delete(); s_aw = 0; s_w = 0; s_b = 0;
    end else begin
      if (ar_hs_s) r_pend.push_back({ar_cap_addr, 3'd0, ar_cap_id});
      if (r_hs_s) rvalid = 1'b0;
      if (!rvalid) rdata = $urandom;
      rresp = 2'($urandom_range(0, 3));
      if (!rvalid && r_pend.size() > 0 && !hold_r && $urandom_range(0, 2) == 0) begin
        rp = r_pend.pop_front();
        rvalid = 1'b1; rid = rp.id; rdata = mem_word(rp.addr);
      end
      arready = 1'($urandom_range(0, 1));
      awready = ($urandom_range(0, 3) == 0);
      wready  = 1'($urandom_range(0, 1));
      if (aw_hs_s) s_aw++;
      if (w_hs_s) s_w++;
      if (b_hs_s) bvalid = 1'b0;
      if (!bvalid && s_aw > s_b && s_w > s_b && $urandom_range(0, 1) == 1) begin
        bvalid = 1'b1; bid = 4'd1; bresp = 2'($urandom_range(0, 3)); s_b++;
      end
    end
  end

  // Monitor: checks acceptance rules, AXI beats and responses against the scoreboard.
  logic  exp_i, exp_drd, exp_dwr, dexp;
  ar_t   ea;
  w_t    ew;
  drsp_t ed;
  always @(negedge clk) begin
    if (reset) begin
      ar_exp_q.delete(); aw_exp_q.delete(); w_exp_q.delete();
      inst_rsp_q.delete(); data_rsp_q.delete();
      inst_acc = 0; data_acc = 0; ar_hs_s = 0; r_hs_s = 0; aw_hs_s = 0; w_hs_s = 0; b_hs_s = 0;
      rd_busy = 0; rd_id = 0; wr_busy = 0; b_prev = 0; ar_wait = 0;
      wr_acc = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      exp_drd = data_req && !data_wr && !rd_busy && !wr_busy;
      exp_i   = inst_req && !rd_busy && !exp_drd;
      exp_dwr = data_req && data_wr && !wr_busy && (!rd_busy || !rd_id);
      if (inst_req || inst_addr_ok) chk("inst_addr_ok", inst_addr_ok, exp_i);
      if (data_req || data_addr_ok) chk("data_addr_ok", data_addr_ok, exp_drd || exp_dwr);
      inst_acc = inst_addr_ok;
      data_acc = data_addr_ok;

      if (ar_wait) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, ar_wait_addr);
      end
      ar_wait = arvalid && !arready;
      ar_wait_addr = araddr;
      ar_hs_s = arvalid && arready;
      if (ar_hs_s) begin
        ar_cap_addr = araddr; ar_cap_id = arid;
        chk("ar_expected", ar_exp_q.size() > 0, 1);
        if (ar_exp_q.size() > 0) begin
          ea = ar_exp_q.pop_front();
          chk("araddr", araddr, ea.addr);
          chk("arsize", arsize, ea.size);
          chk("arid", arid, ea.id);
          chk("arlen_arburst", {arlen, arburst}, {8'd0, 2'd1});
        end
      end

      r_hs_s = rvalid && rready;
      if (r_hs_s || inst_data_ok) chk("inst_data_ok", inst_data_ok, r_hs_s && rid == 4'd0);
      if (r_hs_s && rid == 4'd0) begin
        chk("inst_rsp_expected", inst_rsp_q.size() > 0, 1);
        if (inst_rsp_q.size() > 0) chk("inst_rdata", inst_rdata, inst_rsp_q.pop_front());
      end
      dexp = (r_hs_s && rid == 4'd1) || b_prev;
      if (dexp || data_data_ok) chk("data_data_ok", data_data_ok, dexp);
      if (data_data_ok) begin
        chk("data_rsp_expected", data_rsp_q.size() > 0, 1);
        if (data_rsp_q.size() > 0) begin
          ed = data_rsp_q.pop_front();
          chk("data_rsp_kind", ed.wr, b_prev);
          if (!ed.wr) chk("data_rdata", data_rdata, ed.rdata);
        end
      end
      if (r_hs_s) rd_busy = 0;

      if (awvalid) chk("awvalid_before_own_hs", aw_cnt < wr_acc, 1);
      if (wvalid) chk("wvalid_before_own_hs", w_cnt < wr_acc, 1);
      if (bready) chk("bready_after_aw_and_w", aw_cnt > b_cnt && w_cnt > b_cnt, 1);
      aw_hs_s = awvalid && awready;
      w_hs_s  = wvalid && wready;
      b_hs_s  = bvalid && bready;
      if (aw_hs_s) begin
        chk("aw_expected", aw_exp_q.size() > 0, 1);
        if (aw_exp_q.size() > 0) begin
          ea = aw_exp_q.pop_front();
          chk("awaddr", awaddr, ea.addr);
          chk("awsize", awsize, ea.size);
          chk("awlen_awburst_awid", {awlen, awburst, awid}, {8'd0, 2'd1, 4'd1});
        end
        aw_cnt++;
      end
      if (w_hs_s) begin
        chk("w_expected", w_exp_q.size() > 0, 1);
        if (w_exp_q.size() > 0) begin
          ew = w_exp_q.pop_front();
          chk("wdata", wdata, ew.data);
          chk("wstrb_wlast_wid", {wstrb, wlast, wid}, {ew.strb, 1'b1, 4'd1});
        end
        w_cnt++;
      end
      if (b_hs_s) begin
        b_cnt++;
        wr_busy = 0;
      end
      b_prev = b_hs_s;

      if (inst_addr_ok) begin
        ar_exp_q.push_back({inst_addr, 1'b0, inst_size, 4'd0});
        inst_rsp_q.push_back(mem_word(inst_addr));
        rd_busy = 1; rd_id = 0;
      end
      if (data_addr_ok && !data_wr) begin
        ar_exp_q.push_back({data_addr, 1'b0, data_size, 4'd1});
        data_rsp_q.push_back({1'b0, mem_word(data_addr)});
        rd_busy = 1; rd_id = 1;
      end
      if (data_addr_ok && data_wr) begin
        aw_exp_q.push_back({data_addr, 1'b0, data_size, 4'd1});
        w_exp_q.push_back({data_wdata, data_wstrb});
        data_rsp_q.push_back({1'b1, 32'd0});
        wr_busy = 1; wr_acc++;
      end
    end
  end

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk);
      done = inst_cmd_q.size() == 0 && data_cmd_q.size() == 0 && !inst_req && !data_req &&
             ar_exp_q.size() == 0 && aw_exp_q.size() == 0 && w_exp_q.size() == 0 &&
             inst_rsp_q.size() == 0 && data_rsp_q.size() == 0 && !rd_busy && !wr_busy && !b_prev;
    end
    chk(name, done, 1);
  endtask

  initial begin
    reset = 1'b1;
    hold_r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr_wdata", awaddr | wdata, 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    inst_cmd_q.push_back(mk(1'b0, 32'h1C00_0000, 2'd2, 4'h0, 32'd0, 4'd0));
    inst_cmd_q.push_back(mk(1'b0, 32'h1C00_0004, 2'd2, 4'h0, 32'd0, 4'd0));
    data_cmd_q.push_back(mk(1'b0, 32'h0000_0100, 2'd2, 4'h0, 32'd0, 4'd0));
    data_cmd_q.push_back(mk(1'b1, 32'h0000_0200, 2'd2, 4'hF, 32'hDEAD_BEEF, 4'd0));
    data_cmd_q.push_back(mk(1'b0, 32'h0000_0204, 2'd2, 4'h0, 32'd0, 4'd0));
    data_cmd_q.push_back(mk(1'b1, 32'h0000_0201, 2'd0, 4'h2, 32'h0000_AB00, 4'd0));
    for (int i = 0; i < 6; i++)
      inst_cmd_q.push_back(mk(1'b0, 32'h1C00_0008 + 4 * i, 2'd2, 4'h0, 32'd0, 4'd1));
    for (int i = 0; i < 250; i++) begin
      inst_cmd_q.push_back(mk(1'b0, $urandom, 2'($urandom_range(0, 2)), 4'h0, 32'd0,
                              4'($urandom_range(0, 3))));
      data_cmd_q.push_back(mk(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)),
                              4'($urandom), $urandom, 4'($urandom_range(0, 3))));
    end
    drain("drain_random");

    hold_r = 1'b1;
    inst_cmd_q.push_back(mk(1'b0, 32'h1C00_0040, 2'd2, 4'h0, 32'd0, 4'd0));
    for (int cyc = 0; cyc < 200 && !rready; cyc++) @(negedge clk);
    chk("reached_read_data_wait", rready, 1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_read_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_mid_read_oks", {inst_data_ok, data_data_ok}, 2'b0);
    @(posedge clk); #2 reset = 1'b0;
    hold_r = 1'b0;
    inst_cmd_q.push_back(mk(1'b0, 32'h1C00_0080, 2'd2, 4'h0, 32'd0, 4'd0));
    data_cmd_q.push_back(mk(1'b1, 32'h0000_0300, 2'd1, 4'h3, 32'h1234_5678, 4'd0));
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts the CPU's two sram-like request channels (instruction fetch, data load/store) into one AXI3 master port. It sits directly downstream of the CPU core top, consuming its memory requests, and upstream of the SoC crossbar. Reads are arbitrated with data priority, and writes run on an independent FSM. At most one read and one write are in flight, and at most one data-channel transaction is in flight at any time.

Parameters:
ADDR_W, 32, address width for CPU and AXI.
DATA_W, 32, data width; word-sized only.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  instruction read request
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  instruction address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid
inst_rdata  out  32  instruction read data
data_req  in  1  data request
data_wr  in  1  1=write, 0=read
data_size  in  2  as inst_size
data_wstrb  in  4  write byte strobes
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  read data valid or write response
data_rdata  out  32  data read data
arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address
arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constant 0/1/0/0/0
arready  in  1  AXI
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1  AXI
awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address
awlen/awburst/awlock/awcache/awprot  out  8/2/2/4/3  constant 0/1/0/0/0
awready  in  1  AXI
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data; wid=1, wlast=1
wready  in  1  AXI
bid/bresp/bvalid  in  4/2/1  AXI write response
bready  out  1  AXI

Behaviour:
- Reset: both FSMs go to IDLE. arvalid, rready, awvalid, wvalid, bready, addr_ok and data_ok are all 0. Latched addr/size/id/wdata/wstrb are cleared to 0. Reset mid-transaction abandons the transaction with no response.
- Read FSM states: R_IDLE, R_AR, R_R.
- R_IDLE arbitration:
  - data read (data_req & ~data_wr) is eligible only when the write FSM is W_IDLE.
  - data read beats inst_req; inst_req is otherwise always eligible.
  - The winner gets a combinational addr_ok=1 this cycle.
  - Latch araddr and arsize={1'b0,size}. arid=1 for data, 0 for inst.
  - Transition to R_AR.
- R_AR: arvalid=1, held stable until arready. On arvalid&arready go to R_R.
- R_R: rready=1. On rvalid:
  - rid==0: inst_data_ok=1.
  - rid==1: data_data_ok=1.
  - inst_rdata and data_rdata are driven from rdata in that same cycle.
  - Go to R_IDLE. No new read is accepted in that same cycle; new reads are accepted from the next cycle.
- rresp, bresp and rlast are ignored, since every transfer is a single beat.
- Write FSM states: W_IDLE, W_REQ, W_B.
- W_IDLE: data write (data_req & data_wr) is accepted (data_addr_ok=1) only if the read FSM is R_IDLE, or is busy with arid==0.
  - Latch awaddr, awsize, wdata and wstrb.
  - Set awvalid=1 and wvalid=1, then go to W_REQ.
- W_REQ:
  - awvalid drops after its own handshake; wvalid drops after its own handshake.
  - Handshakes may complete in either order or in the same cycle.
  - When both have completed, go to W_B.
- W_B: bready=1. On bvalid: data_data_ok=1 for one cycle, then go to W_IDLE.
- Same-cycle contention, inst read in R_IDLE plus data write in W_IDLE: both are accepted in parallel.
- data_addr_ok is never asserted for both a read and a write in one cycle.
- Data ordering: a data read never issues while a write is in flight, which rules out RAW hazards. The data channel has at most one outstanding transaction, so data_data_ok is unambiguous.
- Request inputs are sampled only in the acceptance cycle; later changes to them are ignored.

Test Plan:
- Inst fetch: inst_req, addr=0x1C000000, size=2; arready=1 next cycle; rvalid with rid=0, rdata=0x02800C0C two cycles later -> inst_addr_ok in cycle 0, arvalid=1 with araddr=0x1C000000 and arsize=2, inst_data_ok=1 and inst_rdata=0x02800C0C, arid=0.
- Arbitration: inst_req and data read (addr 0x100) in the same cycle -> data_addr_ok=1, inst_addr_ok=0, arid=1; inst is accepted only after rvalid returns the FSM to R_IDLE.
- Store: data_wr, addr=0x200, wdata=0xDEADBEEF, wstrb=0xF, size=2; wready 3 cycles before awready -> wvalid drops first, awvalid drops later, bready is asserted only after both, data_data_ok one cycle after bvalid.
- RAW block: data read requested while a write sits in W_B -> data_addr_ok=0 until the cycle after bvalid. An inst read during the same window is accepted.
- Byte store: size=0, wstrb=0x2, addr=0x201 -> awsize=0, wstrb=0x2, awaddr=0x201, awlen=0, awburst=1.
- Reset asserted while in R_R -> the next cycle has arvalid=rready=0, no data_ok, and the FSM is in R_IDLE.
